// File: rtl/pe_row_ctrl_pkg.sv
// rtl/pe_row_ctrl_pkg.sv - shared types and constants for the PE row controller
package pe_row_ctrl_pkg;

  localparam int conv16_width = 16;
  localparam int PE_IN_LEN    = 16;
  localparam int PE_TAPS      = 3;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} pe_row_ctrl_state_t;

  function automatic int out_len(input int in_len, input int taps);
    return in_len - taps + 1;
  endfunction

endpackage

// File: rtl/pe_row_ctrl_psum_fifo.sv
// rtl/pe_row_ctrl_psum_fifo.sv - psum output FIFO with count and row-sized free-space flag
module psum_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int RESERVE = 14,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [CW-1:0]    count,
  output logic             room
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    case ({push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Room is judged on next-cycle occupancy so a row can be issued back to back
  assign room      = (CW'(DEPTH) - count_d) >= CW'(RESERVE);
  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rstn) !(push && count_q == CW'(DEPTH)));

endmodule

// File: rtl/pe_row_ctrl.sv
// rtl/pe_row_ctrl.sv - job sequencer for one 1D systolic PE row
module pe_row_ctrl
  import pe_row_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int IN_LEN      = PE_IN_LEN,
  parameter int TAPS        = PE_TAPS,
  parameter int PSUM_OFFSET = 4,
  parameter int ROW_PERIOD  = 19,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [7:0]                n_rows,
  input  logic [ADDR_W-1:0]         ifmap_base,
  input  logic [ADDR_W-1:0]         filt_base,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         ifm_addr,
  input  logic [conv16_width-1:0]   ifm_rdata,
  output logic [ADDR_W-1:0]         flt_addr,
  input  logic [conv16_width-1:0]   flt_rdata,
  output logic                      pe_en,
  output logic [conv16_width-1:0]   pe_f,
  output logic [conv16_width-1:0]   pe_r,
  input  logic [2*conv16_width-1:0] pe_psum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*conv16_width-1:0] out_data
);

  localparam int OUT_LEN = out_len(IN_LEN, TAPS);
  localparam int KW      = $clog2(ROW_PERIOD + IN_LEN + 1);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [KW-1:0] K_LAST    = KW'(ROW_PERIOD - 1);
  localparam logic [KW-1:0] K_R_END   = KW'(IN_LEN);
  localparam logic [KW-1:0] K_F_END   = KW'(TAPS);
  localparam logic [KW-1:0] K_PUSH_LO = KW'(1 + PSUM_OFFSET);
  localparam logic [KW-1:0] K_PUSH_HI = KW'(PSUM_OFFSET + OUT_LEN);

  if (ROW_PERIOD < 1 + PSUM_OFFSET + OUT_LEN) begin : g_bad_period
    $error("ROW_PERIOD too short for the psum capture window");
  end
  if (FIFO_DEPTH < OUT_LEN) begin : g_bad_depth
    $error("FIFO_DEPTH cannot hold one row of psums");
  end

  pe_row_ctrl_state_t state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [7:0]         row_q, row_d, n_rows_q, n_rows_d;
  logic [ADDR_W-1:0]  ifm_row_q, ifm_row_d, filt_base_q, filt_base_d;
  logic [ADDR_W-1:0]  ifm_addr_q, ifm_addr_d, flt_addr_q, flt_addr_d;
  logic               busy_q, busy_d, done_q, done_d, pe_en_q, pe_en_d;
  logic               r_win_q, r_win_d, f_win_q, f_win_d;
  logic               run_d, row_last, push, pop, fifo_room, fifo_nempty;
  logic [CW-1:0]      fifo_count;
  logic [2*conv16_width-1:0] fifo_head;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    row_d       = row_q;
    n_rows_d    = n_rows_q;
    ifm_row_d   = ifm_row_q;
    filt_base_d = filt_base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    row_last    = ({1'b0, row_q} + 9'd1) >= {1'b0, n_rows_q};
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d      = 1'b1;
          n_rows_d    = n_rows;
          ifm_row_d   = ifmap_base;
          filt_base_d = filt_base;
          row_d       = '0;
          state_d     = (n_rows == 8'd0) ? DONE : LOAD;
        end
      end
      LOAD: if (fifo_room) begin
        state_d = RUN;
        k_d     = '0;
      end
      RUN: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d       = '0;
          row_d     = row_q + 8'd1;
          ifm_row_d = ifm_row_q + ADDR_W'(IN_LEN);
          // LOAD is only occupied when the next row would not fit
          if (row_last)       state_d = FLUSH;
          else if (fifo_room) state_d = RUN;
          else                state_d = LOAD;
        end
      end
      FLUSH: if (fifo_count == '0) state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    run_d      = (state_d == RUN);
    ifm_addr_d = (run_d && k_d < K_R_END) ? ifm_row_d + ADDR_W'(k_d) : ifm_addr_q;
    flt_addr_d = (run_d && k_d < K_F_END) ? filt_base_d + ADDR_W'(k_d) : flt_addr_q;
    pe_en_d    = run_d && (k_d == KW'(1));
    r_win_d    = run_d && (k_d != '0) && (k_d <= K_R_END);
    f_win_d    = run_d && (k_d != '0) && (k_d <= K_F_END);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      row_q       <= '0;
      n_rows_q    <= '0;
      ifm_row_q   <= '0;
      filt_base_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ifm_addr_q  <= '0;
      flt_addr_q  <= '0;
      pe_en_q     <= 1'b0;
      r_win_q     <= 1'b0;
      f_win_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      row_q       <= row_d;
      n_rows_q    <= n_rows_d;
      ifm_row_q   <= ifm_row_d;
      filt_base_q <= filt_base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ifm_addr_q  <= ifm_addr_d;
      flt_addr_q  <= flt_addr_d;
      pe_en_q     <= pe_en_d;
      r_win_q     <= r_win_d;
      f_win_q     <= f_win_d;
    end
  end

  assign push = (state_q == RUN) && (k_q >= K_PUSH_LO) && (k_q <= K_PUSH_HI);
  assign pop  = fifo_nempty && out_ready;

  psum_fifo #(
    .WIDTH   (2*conv16_width),
    .DEPTH   (FIFO_DEPTH),
    .RESERVE (OUT_LEN)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (pe_psum),
    .pop       (pop),
    .head_data (fifo_head),
    .not_empty (fifo_nempty),
    .count     (fifo_count),
    .room      (fifo_room)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ifm_addr  = ifm_addr_q;
  assign flt_addr  = flt_addr_q;
  assign pe_en     = pe_en_q;
  assign pe_r      = r_win_q ? ifm_rdata : '0;
  assign pe_f      = f_win_q ? flt_rdata : '0;
  assign out_valid = fifo_nempty;
  assign out_data  = fifo_nempty ? fifo_head : '0;

endmodule
